// File: rtl/monitor_scheduler.sv
// Purpose : multi-channel transient monitor; one round-robin arbitrated hold-off timer shared by NUM_CH inputs.
// Latency : invalid edge flags the channel after 1 edge, grant after 2, release L+2 edges after the event.
// Backpressure: none; events arriving while the timer is busy queue as pending bits (one per channel).
//
// Ports:
//   i_clk, i_reset      clock, asynchronous active-high reset
//   i_enable            0 aborts all activity and forces every channel valid
//   i_signal[NUM_CH]    monitored inputs; i_polarity[NUM_CH] gives each channel's valid level
//   i_compare[4]        hold-off length in steps minus one, sampled at timer load
//   o_valid[NUM_CH]     per-channel valid flag (registered-state decode)
//   o_busy, o_active_ch shared timer running / channel owning it
//   o_event_count[8]    saturating accepted-event count, built only with MONITOR_STATS_EN defined
module monitor_scheduler #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 18,
  parameter int TICKS_PER_STEP = 10000
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic [NUM_CH-1:0]         i_signal,
  input  logic [NUM_CH-1:0]         i_polarity,
  input  logic [3:0]                i_compare,
  output logic [NUM_CH-1:0]         o_valid,
  output logic                      o_busy,
  output logic [$clog2(NUM_CH)-1:0] o_active_ch,
  output logic [7:0]                o_event_count
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int LW   = CNT_W + 4;
  localparam logic [LW-1:0] TPS_W = LW'(TICKS_PER_STEP);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [NUM_CH-1:0] r_buf;
  logic [NUM_CH-1:0] pending, pending_nxt;
  logic [CNT_W-1:0]  counter, counter_nxt;
  logic [CH_W-1:0]   r_last, last_nxt;
  logic [CH_W-1:0]   active_ch, active_nxt;

  logic [NUM_CH-1:0] evt;
  logic [NUM_CH-1:0] active_mask;
  logic [NUM_CH-1:0] set_mask;
  logic [NUM_CH-1:0] grant_mask;
  logic              grant_vld;
  logic [CH_W-1:0]   grant_ch;
  logic [LW-1:0]     load_wide;
  logic [CNT_W-1:0]  load_val;

  // Edge into the invalid level: input differs from last sample and now equals ~polarity.
  assign evt = {NUM_CH{i_enable}} & (i_signal ^ r_buf) & (i_signal ^ i_polarity);

  assign o_busy      = (state == COUNT);
  assign o_active_ch = active_ch;

  always_comb begin
    active_mask = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      active_mask[c] = o_busy && (active_ch == CH_W'(c));
    end
  end

  // Events on the channel currently holding the timer retrigger it instead of queueing.
  assign set_mask = evt & ~active_mask;
  assign o_valid  = ~(pending | active_mask);

  // Hold-off load value, computed wide so large step counts saturate instead of wrapping.
  assign load_wide = TPS_W * (LW'(i_compare) + LW'(1)) - LW'(1);
  assign load_val  = (|load_wide[LW-1:CNT_W]) ? {CNT_W{1'b1}} : load_wide[CNT_W-1:0];

  // Round-robin search starting one past the last owner.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!grant_vld && pending[(int'(r_last) + i) % NUM_CH]) begin
        grant_vld = 1'b1;
        grant_ch  = CH_W'((int'(r_last) + i) % NUM_CH);
      end
    end
  end

  always_comb begin
    grant_mask = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      grant_mask[c] = grant_vld && (grant_ch == CH_W'(c));
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending | set_mask;
    counter_nxt = counter;
    last_nxt    = r_last;
    active_nxt  = active_ch;
    if (!i_enable) begin
      state_nxt   = IDLE;
      pending_nxt = '0;
      counter_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            pending_nxt = (pending | set_mask) & ~grant_mask;
            active_nxt  = grant_ch;
            last_nxt    = grant_ch;
            counter_nxt = load_val;
            state_nxt   = COUNT;
          end
        end
        COUNT: begin
          // A retrigger takes priority over expiry on the same cycle.
          if (|(evt & active_mask)) begin
            counter_nxt = load_val;
          end else if (counter == '0) begin
            state_nxt = IDLE;
          end else begin
            counter_nxt = counter - CNT_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      r_buf     <= '0;
      pending   <= '0;
      counter   <= '0;
      r_last    <= CH_W'(NUM_CH - 1);
      active_ch <= '0;
    end else begin
      state     <= state_nxt;
      r_buf     <= i_signal;
      pending   <= pending_nxt;
      counter   <= counter_nxt;
      r_last    <= last_nxt;
      active_ch <= active_nxt;
    end
  end

`ifdef MONITOR_STATS_EN
  logic [NUM_CH-1:0] accept_mask;
  logic [3:0]        accept_num;
  logic [8:0]        count_sum;
  logic [7:0]        event_count;

  // Accepted = pending bit newly set, or retrigger of the active channel.
  assign accept_mask = (set_mask & ~pending) | (evt & active_mask);

  always_comb begin
    accept_num = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      accept_num = accept_num + 4'(accept_mask[c]);
    end
  end

  assign count_sum = {1'b0, event_count} + 9'(accept_num);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      event_count <= '0;
    end else begin
      event_count <= count_sum[8] ? 8'hFF : count_sum[7:0];
    end
  end

  assign o_event_count = event_count;
`else
  assign o_event_count = 8'd0;
`endif

endmodule

// File: tb/tb_monitor_scheduler.sv
// Purpose : directed bench for monitor_scheduler with a grant scoreboard (owner, busy length) plus spot checks.
// Latency : n/a (bench).
// Backpressure: n/a (bench).
`timescale 1ns/1ps
module tb_monitor_scheduler;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_enable = 1'b1;
  logic [3:0] i_signal = 4'hF;
  logic [3:0] i_polarity = 4'hF;
  logic [3:0] i_compare = 4'd0;
  logic [3:0] o_valid;
  logic       o_busy;
  logic [1:0] o_active_ch;
  logic [7:0] o_event_count;

  // Second instance with a narrow counter to exercise load saturation.
  logic [3:0] s_signal = 4'hF;
  logic [3:0] s_compare = 4'd0;
  logic [3:0] s_valid;
  logic       s_busy;
  logic [1:0] s_active_ch;
  logic [7:0] s_event_count;

`ifdef MONITOR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  monitor_scheduler #(.NUM_CH(4), .CNT_W(18), .TICKS_PER_STEP(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable),
    .i_signal(i_signal), .i_polarity(i_polarity), .i_compare(i_compare),
    .o_valid(o_valid), .o_busy(o_busy), .o_active_ch(o_active_ch),
    .o_event_count(o_event_count)
  );

  monitor_scheduler #(.NUM_CH(4), .CNT_W(4), .TICKS_PER_STEP(4)) dut_sat (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(1'b1),
    .i_signal(s_signal), .i_polarity(4'hF), .i_compare(s_compare),
    .o_valid(s_valid), .o_busy(s_busy), .o_active_ch(s_active_ch),
    .o_event_count(s_event_count)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_cnt(input int n);
    return STATS ? n : 0;
  endfunction

  // Scoreboard: expected (owner, busy cycles) per grant, popped when busy falls.
  int exp_ch_q[$];
  int exp_dur_q[$];
  logic busy_d = 1'b0;
  int rise_cyc = 0;
  int rise_ch = 0;
  int e_ch, e_dur;

  always @(negedge i_clk) begin
    if (o_busy && !busy_d) begin
      rise_cyc = cyc;
      rise_ch  = int'(o_active_ch);
    end
    if (!o_busy && busy_d) begin
      if (exp_ch_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL grant_unexpected: owner %0d busy %0d cycles, none expected", rise_ch, cyc - rise_cyc);
      end else begin
        e_ch  = exp_ch_q.pop_front();
        e_dur = exp_dur_q.pop_front();
        check("grant_owner", rise_ch, e_ch);
        check("grant_busy_cycles", cyc - rise_cyc, e_dur);
      end
    end
    busy_d = o_busy;
  end

  task automatic expect_grant(input int ch, input int dur);
    exp_ch_q.push_back(ch);
    exp_dur_q.push_back(dur);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    step();
    step();
    i_reset = 1'b0;
    step();
  endtask

  // Steps until each masked channel's o_valid is high; records step index (-1 if bound expires).
  int rise_at[4];
  task automatic wait_rises(input logic [3:0] mask, input int bound);
    bit done;
    for (int c = 0; c < 4; c++) rise_at[c] = mask[c] ? -1 : 0;
    for (int k = 1; k <= bound; k++) begin
      step();
      done = 1'b1;
      for (int c = 0; c < 4; c++) begin
        if (mask[c] && rise_at[c] < 0 && o_valid[c]) rise_at[c] = k;
        if (mask[c] && rise_at[c] < 0) done = 1'b0;
      end
      if (done) break;
    end
  endtask

  task automatic sat_run(input logic [3:0] cmp, input int exp_len, input string name);
    int len;
    bit seen;
    len = 0;
    seen = 1'b0;
    s_compare = cmp;
    s_signal[0] = 1'b0;
    step();
    s_signal[0] = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (s_busy) begin
        len++;
        seen = 1'b1;
      end else if (seen) begin
        break;
      end
      step();
    end
    check(name, len, exp_len);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (3) step();
    check("rst_valid", o_valid, 4'hF);
    check("rst_busy", o_busy, 1'b0);
    check("rst_active", o_active_ch, 2'd0);
    check("rst_count", o_event_count, 8'd0);
    i_reset = 1'b0;
    step();
    check("first_cycle_valid", o_valid, 4'hF);
    check("first_cycle_busy", o_busy, 1'b0);

    // Single channel hold-off, compare=2 -> L=11
    i_compare = 4'd2;
    expect_grant(0, 12);
    i_signal[0] = 1'b0;
    step();
    check("t2_pend_valid", o_valid, 4'hE);
    check("t2_pend_busy", o_busy, 1'b0);
    i_signal[0] = 1'b1;
    step();
    check("t2_grant_active", o_active_ch, 2'd0);
    check("t2_grant_busy", o_busy, 1'b1);
    wait_rises(4'b0001, 40);
    check("t2_low_cycles", rise_at[0] + 1, 13);
    check("t2_count", o_event_count, exp_cnt(1));

    // Queued channels: ch1+ch3 together, ch0 during ch1 hold -> 1,3,0
    do_reset();
    expect_grant(1, 12);
    expect_grant(3, 12);
    expect_grant(0, 12);
    i_signal = 4'b0101;
    step();
    i_signal = 4'hF;
    check("t3_pend_valid", o_valid, 4'b0101);
    step();
    check("t3_first_owner", o_active_ch, 2'd1);
    step();
    i_signal[0] = 1'b0;
    step();
    i_signal[0] = 1'b1;
    check("t3_queue_valid", o_valid, 4'b0100);
    wait_rises(4'b1011, 60);
    check("t3_rise_ch1", rise_at[1], 10);
    check("t3_rise_ch3", rise_at[3], 23);
    check("t3_rise_ch0", rise_at[0], 36);
    check("t3_count", o_event_count, exp_cnt(3));

    // Retrigger of active ch2 with 2 counts left, new compare=1 -> L=7
    expect_grant(2, 18);
    i_signal[2] = 1'b0;
    step();
    i_signal[2] = 1'b1;
    repeat (5) step();
    i_compare = 4'd1;
    repeat (5) step();
    check("t4_owner", o_active_ch, 2'd2);
    i_signal[2] = 1'b0;
    step();
    i_signal[2] = 1'b1;
    check("t4_retrig_valid", o_valid, 4'b1011);
    wait_rises(4'b0100, 40);
    check("t4_release", rise_at[2], 8);
    check("t4_count", o_event_count, exp_cnt(5));

    // Asynchronous reset mid-count with ch1 pending
    i_compare = 4'd2;
    expect_grant(0, 4);
    i_signal[0] = 1'b0;
    step();
    i_signal[0] = 1'b1;
    step();
    check("t5_owner", o_active_ch, 2'd0);
    step();
    i_signal[1] = 1'b0;
    step();
    i_signal[1] = 1'b1;
    check("t5_pend_valid", o_valid, 4'b1100);
    step();
    step();
    #2;
    i_reset = 1'b1;
    #1;
    check("t5_async_valid", o_valid, 4'hF);
    check("t5_async_busy", o_busy, 1'b0);
    check("t5_async_active", o_active_ch, 2'd0);
    check("t5_async_count", o_event_count, 8'd0);
    step();
    step();
    i_reset = 1'b0;
    step();
    expect_grant(0, 12);
    expect_grant(1, 12);
    i_signal = 4'b1100;
    step();
    i_signal = 4'hF;
    step();
    check("t5_prio_owner", o_active_ch, 2'd0);
    wait_rises(4'b0011, 60);
    check("t5_rise_ch0", rise_at[0], 12);
    check("t5_rise_ch1", rise_at[1], 25);

    // Enable drop during count with ch3 pending
    expect_grant(2, 4);
    i_signal[2] = 1'b0;
    step();
    i_signal[2] = 1'b1;
    step();
    check("t6_owner", o_active_ch, 2'd2);
    i_signal[3] = 1'b0;
    step();
    i_signal[3] = 1'b1;
    check("t6_pend_valid", o_valid, 4'b0011);
    step();
    step();
    i_enable = 1'b0;
    step();
    check("t6_dis_valid", o_valid, 4'hF);
    check("t6_dis_busy", o_busy, 1'b0);
    check("t6_dis_active_held", o_active_ch, 2'd2);
    i_signal[0] = 1'b0;
    step();
    check("t6_dis_noflag", o_valid, 4'hF);
    step();
    i_enable = 1'b1;
    step();
    check("t6_reen_valid", o_valid, 4'hF);
    check("t6_reen_busy", o_busy, 1'b0);
    i_signal[0] = 1'b1;
    step();
    check("t6_count", o_event_count, exp_cnt(4));

    // Load saturation on a 4-bit counter, TICKS_PER_STEP=4
    sat_run(4'd2, 12, "sat_cmp2_busy");
    sat_run(4'd3, 16, "sat_cmp3_busy");
    sat_run(4'd4, 16, "sat_cmp4_busy");

    repeat (3) step();
    check("scoreboard_drained", exp_ch_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
